// File: rtl/count8down_fsm.sv
// 8-bit loadable down counter with registered borrow pulse and zero flag.
// AUTO_RELOAD selects between wrap-to-FF and reload-last-value on underflow.

module count8down_bit_dff (
   input  logic clk,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk) begin
      q <= d;
   end

endmodule

module count8down_dec8 (
   input  logic [7:0] a,
   output logic [7:0] y
);

   logic [7:0] borrow;

   assign borrow[0] = 1'b1;

   // Ripple-borrow subtract-by-one; the borrow out of bit 7 is not needed.
   genvar i;
   generate
      for (i = 1; i < 8; i++) begin : g_borrow
         assign borrow[i] = ~a[i-1] & borrow[i-1];
      end
   endgenerate

   assign y = a ^ borrow;

endmodule

module count8down_mux8 (
   input  logic       sel,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);

   assign y = sel ? b : a;

endmodule

module count8down_fsm #(
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic       clk,
   input  logic       res,
   input  logic       EN,
   input  logic       load,
   input  logic [7:0] CNT_In,
   output logic [7:0] CNT,
   output logic       ZERO,
   output logic       BO
);

   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_DEC   = 2'd2,
      OP_RESET = 2'd3
   } op_e;

   op_e        op;
   logic [7:0] state;
   logic [7:0] rld;
   logic       bo_q;
   logic [7:0] state_d;
   logic [7:0] rld_d;
   logic       bo_d;
   logic [7:0] dec_val;
   logic [7:0] wrap_val;
   logic [7:0] step_val;
   logic       is_zero;
   logic       wrap_sel;

   assign is_zero  = (state == 8'h00);
   assign wrap_sel = AUTO_RELOAD;

   always_comb begin
      op = OP_HOLD;
      if (res) begin
         op = OP_RESET;
      end else if (load) begin
         op = OP_LOAD;
      end else if (EN) begin
         op = OP_DEC;
      end
   end

   count8down_dec8 u_dec (
      .a (state),
      .y (dec_val)
   );

   count8down_mux8 u_wrap_mux (
      .sel (wrap_sel),
      .a   (8'hFF),
      .b   (rld),
      .y   (wrap_val)
   );

   count8down_mux8 u_step_mux (
      .sel (is_zero),
      .a   (dec_val),
      .b   (wrap_val),
      .y   (step_val)
   );

   // Reset is folded into the D path so the flops themselves stay reset-free.
   always_comb begin
      state_d = state;
      rld_d   = rld;
      bo_d    = 1'b0;
      case (op)
         OP_RESET: begin
            state_d = 8'h00;
            rld_d   = 8'h00;
         end
         OP_LOAD: begin
            state_d = CNT_In;
            rld_d   = CNT_In;
         end
         OP_DEC: begin
            state_d = step_val;
            bo_d    = is_zero;
         end
         default: begin
            state_d = state;
         end
      endcase
   end

   genvar i;
   generate
      for (i = 0; i < 8; i++) begin : g_regs
         count8down_bit_dff u_state_ff (
            .clk (clk),
            .d   (state_d[i]),
            .q   (state[i])
         );
         count8down_bit_dff u_rld_ff (
            .clk (clk),
            .d   (rld_d[i]),
            .q   (rld[i])
         );
      end
   endgenerate

   count8down_bit_dff u_bo_ff (
      .clk (clk),
      .d   (bo_d),
      .q   (bo_q)
   );

   assign CNT  = state;
   assign ZERO = is_zero;
   assign BO   = bo_q;

endmodule

// File: tb/tb_count8down_fsm.sv
// Scoreboard bench for count8down_fsm: one instance per AUTO_RELOAD setting,
// directed vectors push expectations that per-instance monitors check.

module tb_count8down_fsm;

   typedef struct {
      logic [7:0] cnt;
      logic       bo;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       res0 = 1'b1, en0 = 1'b0, load0 = 1'b0;
   logic       res1 = 1'b1, en1 = 1'b0, load1 = 1'b0;
   logic [7:0] in0 = 8'h00, in1 = 8'h00;
   logic [7:0] cnt0, cnt1;
   logic       zero0, zero1, bo0, bo1;

   exp_t q0[$];
   exp_t q1[$];
   int   numCompared = 0;
   int   numMismatched = 0;

   always #5 clk = ~clk;

   count8down_fsm #(.AUTO_RELOAD(1'b0)) u_dut_wrap (
      .clk    (clk),
      .res    (res0),
      .EN     (en0),
      .load   (load0),
      .CNT_In (in0),
      .CNT    (cnt0),
      .ZERO   (zero0),
      .BO     (bo0)
   );

   count8down_fsm #(.AUTO_RELOAD(1'b1)) u_dut_reload (
      .clk    (clk),
      .res    (res1),
      .EN     (en1),
      .load   (load1),
      .CNT_In (in1),
      .CNT    (cnt1),
      .ZERO   (zero1),
      .BO     (bo1)
   );

   task automatic checkOutput(input string who, input logic [7:0] actCnt, input logic actZero,
                              input logic actBo, input exp_t e);
      logic expZero;
      expZero = (e.cnt == 8'h00);
      numCompared++;
      if (actCnt !== e.cnt) begin
         numMismatched++;
         $display("[TB] FAIL %s %s CNT: got %h expected %h", who, e.tag, actCnt, e.cnt);
      end
      numCompared++;
      if (actZero !== expZero) begin
         numMismatched++;
         $display("[TB] FAIL %s %s ZERO: got %b expected %b", who, e.tag, actZero, expZero);
      end
      numCompared++;
      if (actBo !== e.bo) begin
         numMismatched++;
         $display("[TB] FAIL %s %s BO: got %b expected %b", who, e.tag, actBo, e.bo);
      end
   endtask

   // Inputs change on the falling edge; the expectation describes the outputs after the next rising edge.
   task automatic applyStimulus(input int dutSel, input logic r, input logic e, input logic l,
                                input logic [7:0] d, input logic [7:0] expCnt, input logic expBo,
                                input string tag);
      exp_t x;
      @(negedge clk);
      x.cnt = expCnt;
      x.bo  = expBo;
      x.tag = tag;
      if (dutSel == 0) begin
         res0 = r; en0 = e; load0 = l; in0 = d;
         q0.push_back(x);
      end else begin
         res1 = r; en1 = e; load1 = l; in1 = d;
         q1.push_back(x);
      end
      @(posedge clk);
   endtask

   always begin : mon_wrap
      exp_t e;
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         checkOutput("wrap", cnt0, zero0, bo0, e);
      end
   end

   always begin : mon_reload
      exp_t e;
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
         e = q1.pop_front();
         checkOutput("reload", cnt1, zero1, bo1, e);
      end
   end

   initial begin
      logic [7:0] seqA [9];
      logic       boA  [9];
      seqA = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
      boA  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      // Reset dominates load and enable.
      applyStimulus(0, 1, 1, 1, 8'hA5, 8'h00, 0, "reset1");
      applyStimulus(0, 1, 1, 1, 8'hA5, 8'h00, 0, "reset2");

      // Load 3 and count through the wrap.
      applyStimulus(0, 0, 0, 1, 8'h03, 8'h03, 0, "load03");
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h02, 0, "dec02");
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h01, 0, "dec01");
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h00, 0, "dec00");
      applyStimulus(0, 0, 1, 0, 8'h00, 8'hFF, 1, "wrapFF");
      applyStimulus(0, 0, 1, 0, 8'h00, 8'hFE, 0, "decFE");

      // Load beats enable, then hold.
      applyStimulus(0, 0, 0, 1, 8'h10, 8'h10, 0, "load10");
      applyStimulus(0, 0, 1, 1, 8'h40, 8'h40, 0, "loadPrio");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 8'h00, 8'h40, 0, "hold40");
      end

      // Full 256-step wrap starting from zero.
      applyStimulus(0, 0, 0, 1, 8'h00, 8'h00, 0, "load00");
      for (int i = 0; i < 256; i++) begin
         applyStimulus(0, 0, 1, 0, 8'h00, 8'(8'hFF - i), (i == 0), "fullWrap");
      end
      applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 0, "fullWrapHold");

      // Auto-reload instance.
      applyStimulus(1, 1, 1, 1, 8'hA5, 8'h00, 0, "reset");
      applyStimulus(1, 0, 0, 1, 8'h02, 8'h02, 0, "load02");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1, 0, 1, 0, 8'h00, seqA[i], boA[i], "autoReload");
      end

      // Reset mid-count clears the reload value too.
      applyStimulus(1, 0, 0, 1, 8'h05, 8'h05, 0, "load05");
      applyStimulus(1, 0, 1, 0, 8'h00, 8'h04, 0, "dec04");
      applyStimulus(1, 0, 1, 0, 8'h00, 8'h03, 0, "dec03");
      applyStimulus(1, 0, 1, 0, 8'h00, 8'h02, 0, "dec02");
      applyStimulus(1, 1, 1, 0, 8'h00, 8'h00, 0, "midReset");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 1, 0, 8'h00, 8'h00, 1, "zeroReload");
      end
      applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 0, "holdClearsBo");

      // Drain: any expectation still queued after a few cycles is a failure.
      for (int i = 0; i < 4 && (q0.size() + q1.size()) > 0; i++) begin
         @(posedge clk);
         #2;
      end
      numCompared++;
      if ((q0.size() + q1.size()) != 0) begin
         numMismatched++;
         $display("[TB] FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
